// File: rtl/store_commit_arbiter.sv
// store_commit_arbiter: buffers retired stores and issues them in program order to the single D-cache write port.
module store_commit_arbiter #(
  parameter int N_WAY     = 2,
  parameter int N_SQ      = 8,
  parameter int XLEN      = 32,
  parameter int BUF_DEPTH = 4
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [N_WAY-1:0]                    ret_valid,
  input  logic [N_WAY*XLEN-1:0]               ret_address,
  input  logic [N_WAY*XLEN-1:0]               ret_data,
  input  logic [N_WAY*2-1:0]                  ret_size,
  input  logic [N_WAY*($clog2(N_SQ)+1)-1:0]   ret_store_pos,
  output logic [$clog2(BUF_DEPTH):0]          free_slots,
  output logic                                dc_wr_valid,
  output logic [XLEN-1:0]                     dc_wr_addr,
  output logic [XLEN-1:0]                     dc_wr_data,
  output logic [3:0]                          dc_wr_be,
  input  logic                                dc_wr_ready,
  output logic                                done_valid,
  output logic [$clog2(N_SQ):0]               done_store_pos,
  output logic                                misalign_err,
  output logic                                overflow_err,
  input  logic                                drain_req,
  output logic                                drained
);
  localparam int PW = $clog2(N_SQ) + 1;
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int IW = $clog2(BUF_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t state, state_n;
  logic [IW-1:0] head, tail;
  logic [CW-1:0] count, cnt_n, n_enq;
  logic [XLEN-1:0] b_addr [BUF_DEPTH];
  logic [XLEN-1:0] b_data [BUF_DEPTH];
  logic [1:0] b_size [BUF_DEPTH];
  logic [PW-1:0] b_pos [BUF_DEPTH];
  logic [N_WAY-1:0] wr_en;
  logic [IW-1:0] wr_idx [N_WAY];
  logic drop, act, mis, deq;
  logic [XLEN-1:0] h_addr, h_data;
  logic [1:0] h_size;

  assign free_slots = CW'(BUF_DEPTH) - count;
  assign h_addr = b_addr[head];
  assign h_data = b_data[head];
  assign h_size = b_size[head];

  // Valid lanes are packed into consecutive slots; lanes beyond the free space are dropped.
  always_comb begin
    n_enq = '0;
    drop = 1'b0;
    wr_en = '0;
    wr_idx = '{default: '0};
    for (int i = 0; i < N_WAY; i++) begin
      if (ret_valid[i]) begin
        if (n_enq < free_slots) begin
          wr_en[i] = 1'b1;
          wr_idx[i] = IW'((int'(tail) + int'(n_enq)) % BUF_DEPTH);
          n_enq = n_enq + CW'(1);
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  assign act = state != IDLE && count != '0;
  assign mis = h_size[1] ? h_addr[1:0] != 2'b00 : h_size[0] & h_addr[0];
  assign dc_wr_valid = act & ~mis;
  assign deq = act & (mis | dc_wr_ready);
  assign dc_wr_addr = dc_wr_valid ? {h_addr[XLEN-1:2], 2'b00} : '0;
  assign dc_wr_be = !dc_wr_valid ? 4'b0000 :
                    h_size[1] ? 4'b1111 :
                    h_size[0] ? 4'b0011 << h_addr[1:0] : 4'b0001 << h_addr[1:0];
  assign dc_wr_data = !dc_wr_valid ? '0 :
                      h_size[1] ? h_data :
                      h_size[0] ? {2{h_data[15:0]}} : {4{h_data[7:0]}};
  assign drained = state == DRAIN && drain_req && count == '0;
  assign cnt_n = count + n_enq - CW'(deq);

  always_comb begin
    state_n = drain_req ? DRAIN :
              state == DRAIN ? IDLE :
              cnt_n != '0 ? ISSUE : IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      head <= '0;
      tail <= '0;
      count <= '0;
      done_valid <= 1'b0;
      done_store_pos <= '0;
      misalign_err <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      state <= state_n;
      count <= cnt_n;
      tail <= IW'((int'(tail) + int'(n_enq)) % BUF_DEPTH);
      head <= deq ? IW'((int'(head) + 1) % BUF_DEPTH) : head;
      done_valid <= deq;
      done_store_pos <= deq ? b_pos[head] : '0;
      misalign_err <= act & mis;
      overflow_err <= overflow_err | drop;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < N_WAY; i++) begin
      if (wr_en[i]) begin
        b_addr[wr_idx[i]] <= ret_address[i*XLEN +: XLEN];
        b_data[wr_idx[i]] <= ret_data[i*XLEN +: XLEN];
        b_size[wr_idx[i]] <= ret_size[i*2 +: 2];
        b_pos[wr_idx[i]] <= ret_store_pos[i*PW +: PW];
      end
    end
  end
endmodule

// File: tb/tb_store_commit_arbiter.sv
// tb_store_commit_arbiter: directed checks of ordering, lane generation, backpressure, overflow, misalignment, drain and reset.
module tb_store_commit_arbiter;
  logic clock, reset;
  logic [1:0] ret_valid;
  logic [63:0] ret_address, ret_data;
  logic [3:0] ret_size;
  logic [7:0] ret_store_pos;
  logic [2:0] free_slots;
  logic dc_wr_valid, dc_wr_ready;
  logic [31:0] dc_wr_addr, dc_wr_data;
  logic [3:0] dc_wr_be;
  logic done_valid;
  logic [3:0] done_store_pos;
  logic misalign_err, overflow_err, drain_req, drained;
  int vecs = 0, miss = 0;
  int sent, done_cnt;
  logic [15:0] pat = 16'hB2E5;

  store_commit_arbiter dut (
    .clock(clock), .reset(reset), .ret_valid(ret_valid), .ret_address(ret_address),
    .ret_data(ret_data), .ret_size(ret_size), .ret_store_pos(ret_store_pos),
    .free_slots(free_slots), .dc_wr_valid(dc_wr_valid), .dc_wr_addr(dc_wr_addr),
    .dc_wr_data(dc_wr_data), .dc_wr_be(dc_wr_be), .dc_wr_ready(dc_wr_ready),
    .done_valid(done_valid), .done_store_pos(done_store_pos), .misalign_err(misalign_err),
    .overflow_err(overflow_err), .drain_req(drain_req), .drained(drained)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic lane(input int i, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s, input logic [3:0] p);
    ret_valid[i] = 1'b1;
    ret_address[i*32 +: 32] = a;
    ret_data[i*32 +: 32] = d;
    ret_size[i*2 +: 2] = s;
    ret_store_pos[i*4 +: 4] = p;
  endtask

  task automatic clr();
    ret_valid = '0;
    ret_address = '0;
    ret_data = '0;
    ret_size = '0;
    ret_store_pos = '0;
  endtask

  initial begin
    reset = 1'b1;
    dc_wr_ready = 1'b0;
    drain_req = 1'b0;
    clr();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("rst_valid", dc_wr_valid, 0);
    chk("rst_addr", dc_wr_addr, 0);
    chk("rst_data", dc_wr_data, 0);
    chk("rst_be", dc_wr_be, 0);
    chk("rst_done", done_valid, 0);
    chk("rst_pos", done_store_pos, 0);
    chk("rst_mis", misalign_err, 0);
    chk("rst_ovf", overflow_err, 0);
    chk("rst_drained", drained, 0);
    chk("rst_free", free_slots, 4);

    // single WORD store
    lane(0, 32'h104, 32'hDEADBEEF, 2, 3);
    dc_wr_ready = 1'b1;
    @(negedge clock);
    clr();
    chk("w_valid", dc_wr_valid, 1);
    chk("w_addr", dc_wr_addr, 32'h104);
    chk("w_be", dc_wr_be, 4'hF);
    chk("w_data", dc_wr_data, 32'hDEADBEEF);
    chk("w_free", free_slots, 3);
    chk("w_nodone", done_valid, 0);
    @(negedge clock);
    chk("w_done", done_valid, 1);
    chk("w_pos", done_store_pos, 3);
    chk("w_idle", dc_wr_valid, 0);
    chk("w_free2", free_slots, 4);
    @(negedge clock);
    chk("w_done_off", done_valid, 0);
    chk("w_pos_off", done_store_pos, 0);

    // BYTE then HALF in one retire cycle
    lane(0, 32'h203, 32'h000000AB, 0, 1);
    lane(1, 32'h202, 32'h00001234, 1, 2);
    @(negedge clock);
    clr();
    chk("b_be", dc_wr_be, 4'b1000);
    chk("b_data", dc_wr_data, 32'hABABABAB);
    chk("b_addr", dc_wr_addr, 32'h200);
    chk("b_free", free_slots, 2);
    @(negedge clock);
    chk("b_pos", done_store_pos, 1);
    chk("h_be", dc_wr_be, 4'b1100);
    chk("h_data", dc_wr_data, 32'h12341234);
    @(negedge clock);
    chk("h_pos", done_store_pos, 2);
    chk("h_idle", dc_wr_valid, 0);

    // backpressure with a full buffer
    dc_wr_ready = 1'b0;
    lane(0, 32'h300, 32'hC0000000, 2, 4);
    lane(1, 32'h304, 32'hC0000001, 2, 5);
    @(negedge clock);
    clr();
    lane(0, 32'h308, 32'hC0000002, 2, 6);
    lane(1, 32'h30C, 32'hC0000003, 2, 7);
    chk("bp_free2", free_slots, 2);
    chk("bp_addr0", dc_wr_addr, 32'h300);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      clr();
      chk("bp_full", free_slots, 0);
      chk("bp_valid", dc_wr_valid, 1);
      chk("bp_addr", dc_wr_addr, 32'h300);
      chk("bp_data", dc_wr_data, 32'hC0000000);
      chk("bp_nodone", done_valid, 0);
    end
    dc_wr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("bp_done", done_valid, 1);
      chk("bp_pos", done_store_pos, 4 + k);
      if (k < 3) chk("bp_next", dc_wr_addr, 32'h304 + 4 * k);
    end
    @(negedge clock);
    chk("bp_end", done_valid, 0);
    chk("bp_ovf", overflow_err, 0);

    // overflow: 3 held, two more offered
    dc_wr_ready = 1'b0;
    lane(0, 32'h500, 32'h1, 2, 1);
    lane(1, 32'h504, 32'h2, 2, 2);
    @(negedge clock);
    clr();
    lane(0, 32'h508, 32'h3, 2, 3);
    @(negedge clock);
    clr();
    chk("of_free", free_slots, 1);
    chk("of_pre", overflow_err, 0);
    lane(0, 32'h50C, 32'h4, 2, 4);
    lane(1, 32'h510, 32'h5, 2, 5);
    @(negedge clock);
    clr();
    chk("of_full", free_slots, 0);
    chk("of_err", overflow_err, 1);
    dc_wr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("of_done", done_valid, 1);
      chk("of_pos", done_store_pos, 1 + k);
    end
    @(negedge clock);
    chk("of_end", done_valid, 0);
    chk("of_free4", free_slots, 4);
    chk("of_sticky", overflow_err, 1);

    // misaligned WORD followed by a BYTE on lane 1
    lane(0, 32'h106, 32'h77777777, 2, 5);
    lane(1, 32'h101, 32'h0000005A, 0, 6);
    @(negedge clock);
    clr();
    chk("ma_noreq", dc_wr_valid, 0);
    chk("ma_nopulse", misalign_err, 0);
    @(negedge clock);
    chk("ma_err", misalign_err, 1);
    chk("ma_done", done_valid, 1);
    chk("ma_pos", done_store_pos, 5);
    chk("ma_next_v", dc_wr_valid, 1);
    chk("ma_next_be", dc_wr_be, 4'b0010);
    chk("ma_next_d", dc_wr_data, 32'h5A5A5A5A);
    @(negedge clock);
    chk("ma_err_off", misalign_err, 0);
    chk("ma_pos2", done_store_pos, 6);

    // drain with irregular ready across pointer wrap
    drain_req = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("dr_empty", drained, 1);
    sent = 0;
    done_cnt = 0;
    for (int k = 0; k < 200 && done_cnt < 10; k++) begin
      clr();
      if (sent < 10 && free_slots != 0) begin
        lane(sent % 2, 32'h400 + 4 * sent, sent, 2, 4'(sent % 8 + 1));
        sent++;
      end
      dc_wr_ready = pat[k % 16];
      @(negedge clock);
      if (k == 0) chk("dr_busy", drained, 0);
      if (done_valid) begin
        chk("dr_pos", done_store_pos, done_cnt % 8 + 1);
        done_cnt++;
        if (done_cnt == 10) chk("dr_drained", drained, 1);
      end
      if (dc_wr_valid) chk("dr_addr", dc_wr_addr, 32'h400 + 4 * done_cnt);
    end
    chk("dr_count", done_cnt, 10);
    clr();
    drain_req = 1'b0;
    @(negedge clock);
    chk("dr_off", drained, 0);

    // reset in the middle of a pending request
    dc_wr_ready = 1'b0;
    lane(0, 32'h600, 32'h9, 2, 1);
    lane(1, 32'h604, 32'hA, 2, 2);
    @(negedge clock);
    clr();
    chk("mr_pend", dc_wr_valid, 1);
    dc_wr_ready = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mr_free", free_slots, 4);
    chk("mr_nodone", done_valid, 0);
    chk("mr_noreq", dc_wr_valid, 0);
    chk("mr_ovf", overflow_err, 0);
    @(negedge clock);
    chk("mr_nodone2", done_valid, 0);
    chk("mr_noreq2", dc_wr_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule

// File: doc/store_commit_arbiter.md
# store_commit_arbiter

Sequences retired stores from the store queue into the single D-cache write port. It buffers up to `N_WAY` retired stores per cycle, presents them one at a time in program order over a valid/ready handshake, and generates byte enables and lane-aligned write data. For each accepted store it returns a one-cycle completion carrying `store_pos`, so the store queue can free that slot. It also gives the ROB retire credits and supports a drain/fence request.

## Interface
- `N_WAY`, 2: retire lanes per cycle.
- `N_SQ`, 8: store-queue entries. `store_pos` is 1-based, width `$clog2(N_SQ)+1`; 0 means none.
- `XLEN`, 32: address and data width.
- `BUF_DEPTH`, 4: commit buffer entries; must be ≥ `N_WAY`.

Ports:
- `clock` in 1: single clock; all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `ret_valid` in `N_WAY`: retired-store valid, one bit per lane; lane 0 is oldest.
- `ret_address` in `N_WAY`×`XLEN`: byte address.
- `ret_data` in `N_WAY`×`XLEN`: store data, right-justified.
- `ret_size` in `N_WAY`×2: BYTE=0, HALF=1, WORD=2; encoding 3 is treated as WORD.
- `ret_store_pos` in `N_WAY`×(`$clog2(N_SQ)+1`): originating SQ slot.
- `free_slots` out `$clog2(BUF_DEPTH)+1`: `BUF_DEPTH` minus occupancy. Combinational from registered state; the ROB must not retire more stores than this.
- `dc_wr_valid` out 1: write request to the D-cache.
- `dc_wr_addr` out `XLEN`: word-aligned address, `{addr[XLEN-1:2],2'b00}`.
- `dc_wr_data` out `XLEN`: data shifted to its byte lane.
- `dc_wr_be` out 4: byte enables.
- `dc_wr_ready` in 1: D-cache accepts the request on a rising edge when `dc_wr_valid` and `dc_wr_ready` are both 1.
- `done_valid` out 1: completion pulse to the store queue.
- `done_store_pos` out `$clog2(N_SQ)+1`: slot being completed; 0 when `done_valid`=0.
- `misalign_err` out 1: one-cycle pulse when a misaligned store is discarded.
- `overflow_err` out 1: sticky; cleared only by reset.
- `drain_req` in 1: fence request.
- `drained` out 1: high when the buffer is empty, no request is pending and `drain_req`=1.

## Operation
- The commit buffer is a circular FIFO with head and tail pointers and a count.
  - Enqueue: valid lanes are compacted in lane order; invalid lanes are skipped, including non-contiguous valid lanes.
  - Up to `N_WAY` entries are written per cycle.
  - Pointers wrap modulo `BUF_DEPTH`.
- Overflow: if the number of valid lanes exceeds `free_slots` (computed before the same-cycle dequeue), the excess youngest lanes are dropped and `overflow_err` is set.
- FSM `IDLE` / `ISSUE` / `DRAIN`:
  - `IDLE`: `dc_wr_valid`=0. Moves to `ISSUE` when count > 0.
  - `ISSUE`: the head entry drives the D-cache outputs.
    - On handshake, the head is dequeued and `done_valid` is asserted.
    - If entries remain after the dequeue, the FSM stays in `ISSUE` with the next entry; otherwise it returns to `IDLE`.
    - Sustained throughput is one store per cycle.
  - `DRAIN`: entered from any state when `drain_req`=1. Issuing continues normally.
    - `drained`=1 while count=0 and no request is pending.
    - Returns to `IDLE` when `drain_req` falls.
- Alignment and lane generation, with `a` = `addr[1:0]`:
  - BYTE: `be` = `4'b0001<<a`; data = `{4{d[7:0]}}`.
  - HALF: `a[0]` must be 0; `be` = `4'b0011<<a`; data = `{2{d[15:0]}}`.
  - WORD: `a` must be 00; `be` = `4'b1111`; data = `d`.
- Misaligned HALF or WORD entry at the head:
  - It is not presented to the D-cache (`dc_wr_valid`=0 that cycle).
  - It is dequeued in one cycle, with `misalign_err`=1 and a `done_valid` pulse so its SQ slot is still freed.
- Branch hazards do not affect this block; retired stores are architecturally committed and always drain.

## Timing
- Reset values: `dc_wr_valid`=0, `dc_wr_addr`/`dc_wr_data`/`dc_wr_be`=0, `done_valid`=0, `done_store_pos`=0, `misalign_err`=0, `overflow_err`=0, `drained`=0, `free_slots`=`BUF_DEPTH`, FSM in `IDLE`.
- Reset mid-operation flushes all entries, including a pending request. No completion is issued.
- Enqueue to request: a store enqueued at edge N is presented with `dc_wr_valid`=1 in cycle N+1 at the earliest. There is no same-cycle bypass.
- Request stability: while `dc_wr_valid`=1 and `dc_wr_ready`=0, the address, data, byte enables and the head entry hold stable.
- Completion: `done_valid` / `done_store_pos` are registered and asserted for exactly one cycle after the accepting edge.
- `free_slots` reflects the post-edge count. Simultaneous enqueue and dequeue in the same cycle are both honoured.
- Full buffer: `free_slots`=0; `dc_wr_valid` stays asserted.

## Test plan
- Single WORD store: `ret_valid`=01, addr 0x104, data 0xDEADBEEF, pos 3, `dc_wr_ready`=1 → next cycle `dc_wr_addr`=0x104, `be`=1111; the following cycle `done_valid`=1 with `done_store_pos`=3.
- BYTE at 0x203 with data 0xAB → `be`=1000, `dc_wr_data`=0xABABABAB. HALF at 0x202 with data 0x1234 → `be`=1100, data 0x12341234.
- Backpressure: 4 stores enqueued with `dc_wr_ready`=0 for 5 cycles → `free_slots`=0 and outputs stable; then ready=1 → 4 completions on consecutive cycles in lane/program order.
- Overflow: count=3, `BUF_DEPTH`=4, `ret_valid`=11 → only lane 0 is enqueued and `overflow_err` is 1 and sticky.
- Misaligned WORD at 0x106, pos 5 → no D-cache request, `misalign_err` pulses, `done_store_pos`=5.
- Wrap and drain: 10 stores with random ready, `drain_req`=1 → all complete in order across pointer wrap, and `drained`=1 after the last completion. Reset asserted mid-stream → `free_slots`=4 and no `done_valid` in the next cycle.
